regbank_write_sched: RTL and testbench

Write-port scheduler for the 32×32 register bank in the multi-cycle processor. Arbitrates round-robin among several writeback sources (ALU result, memory load, link/PC writeback), sequences the bank's level-sensitive write strobe so address and data are stable before and while `sig` is high, and keeps a pending-write busy scoreboard that decode uses to stall on RAW hazards.

---
 rtl/regbank_sched_pkg.sv | 7 +
 rtl/rr_picker.sv | 20 ++
 rtl/regbank_write_sched.sv | 72 +++++++
 tb/tb_regbank_write_sched.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/regbank_sched_pkg.sv
// regbank_sched_pkg: shared state encoding and register-bank geometry for the write scheduler
package regbank_sched_pkg;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
  localparam int NUM_REGS = 32;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE} sched_state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational rotating-priority one-hot picker starting at ptr
module rr_picker #(
  parameter int N = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);
  logic [N-1:0] hi, pick;
  always_comb begin
    // prefer requesters at or above ptr, else wrap to the lowest valid one
    hi = valid & ({N{1'b1}} << ptr);
    pick = |hi ? hi : valid;
    grant = pick & (~pick + N'(1));
    grant_idx = '0;
    for (int i = 0; i < N; i++) if (grant[i]) grant_idx = PW'(i);
  end
endmodule

// File: rtl/regbank_write_sched.sv
// regbank_write_sched: round-robin write-port scheduler with strobe sequencing and RAW busy scoreboard
module regbank_write_sched
  import regbank_sched_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW = REG_DW,
  parameter int AW = REG_AW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_reg,
  input  logic [NREQ*DW-1:0]   req_val,
  output logic                 wr_sig,
  output logic [AW-1:0]        wr_reg,
  output logic [DW-1:0]        wr_val,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_reg,
  output logic [(2**AW)-1:0]   busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  sched_state_t state, state_nx;
  logic [PW-1:0] ptr, gidx, ptr_nx;
  logic [NREQ-1:0] grant;
  logic acc;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_val;
  rr_picker #(.N(NREQ), .PW(PW)) u_pick (
    .valid(req_valid),
    .ptr(ptr),
    .grant(grant),
    .grant_idx(gidx)
  );
  assign acc = (state == IDLE) && |req_valid;
  assign req_ready = (state == IDLE) ? grant : '0;
  assign ptr_nx = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  always_comb begin
    state_nx = (state == IDLE) ? (acc ? SETUP : IDLE) : (state == SETUP) ? STROBE : IDLE;
    sel_reg = '0;
    sel_val = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_reg = sel_reg | (req_reg[i*AW +: AW] & {AW{grant[i]}});
      sel_val = sel_val | (req_val[i*DW +: DW] & {DW{grant[i]}});
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      wr_sig <= 1'b0;
      wr_reg <= '0;
      wr_val <= '0;
    end else begin
      state <= state_nx;
      wr_sig <= (state_nx == STROBE);
      if (acc) begin
        ptr <= ptr_nx;
        wr_reg <= sel_reg;
        wr_val <= sel_val;
      end
    end
  end
  // set is written last so a new reservation overrides the retiring write
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else begin
      if (state == STROBE) busy[wr_reg] <= 1'b0;
      if (rsv_valid) busy[rsv_reg] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regbank_write_sched.sv
// tb_regbank_write_sched: directed vector table plus hand-written corner sequences
module tb_regbank_write_sched;
  localparam int NREQ = 3, DW = 32, AW = 5, NR = 32;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*AW-1:0] req_reg;
  logic [NREQ*DW-1:0] req_val;
  logic wr_sig, rsv_valid;
  logic [AW-1:0] wr_reg, rsv_reg;
  logic [DW-1:0] wr_val;
  logic [NR-1:0] busy;
  logic [DW-1:0] bank [NR];
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] v; logic rv; logic [4:0] rr;
    logic [2:0] rdy; logic sig; logic [4:0] wreg; logic [31:0] wval; logic [31:0] bsy;
  } vec_t;
  vec_t tbl [11];
  always #5 clk = ~clk;
  regbank_write_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_val(req_val), .wr_sig(wr_sig), .wr_reg(wr_reg),
    .wr_val(wr_val), .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .busy(busy)
  );
  always @(posedge clk) if (wr_sig) bank[wr_reg] <= wr_val;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] v);
    req_reg[i*AW +: AW] = r;
    req_val[i*DW +: DW] = v;
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    req_valid = '0; req_reg = '0; req_val = '0; rsv_valid = 0; rsv_reg = '0;
    set_req(0, 4, 100); set_req(1, 5, 101); set_req(2, 6, 102);
    tbl[0]  = '{3'b111, 1, 4, 3'b001, 0, 0, 0,   32'h0};
    tbl[1]  = '{3'b111, 0, 0, 3'b000, 0, 4, 100, 32'h10};
    tbl[2]  = '{3'b111, 0, 0, 3'b000, 1, 4, 100, 32'h10};
    tbl[3]  = '{3'b111, 0, 0, 3'b010, 0, 4, 100, 32'h0};
    tbl[4]  = '{3'b111, 0, 0, 3'b000, 0, 5, 101, 32'h0};
    tbl[5]  = '{3'b111, 1, 5, 3'b000, 1, 5, 101, 32'h0};
    tbl[6]  = '{3'b111, 1, 6, 3'b100, 0, 5, 101, 32'h20};
    tbl[7]  = '{3'b111, 0, 0, 3'b000, 0, 6, 102, 32'h60};
    tbl[8]  = '{3'b111, 0, 0, 3'b000, 1, 6, 102, 32'h60};
    tbl[9]  = '{3'b111, 0, 0, 3'b001, 0, 6, 102, 32'h20};
    tbl[10] = '{3'b111, 0, 0, 3'b000, 0, 4, 100, 32'h20};
    step;
    req_valid = 3'b111;
    #1;
    chk("rst_sig", 64'(wr_sig), 0);
    chk("rst_reg", 64'(wr_reg), 0);
    chk("rst_val", 64'(wr_val), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready111", 64'(req_ready), 3'b001);
    req_valid = 3'b110;
    #1 chk("rst_ready110", 64'(req_ready), 3'b010);
    rst = 0;
    for (int t = 0; t < 11; t++) begin
      req_valid = tbl[t].v; rsv_valid = tbl[t].rv; rsv_reg = tbl[t].rr;
      #1;
      chk($sformatf("rr%0d_ready", t), 64'(req_ready), 64'(tbl[t].rdy));
      chk($sformatf("rr%0d_sig", t), 64'(wr_sig), 64'(tbl[t].sig));
      chk($sformatf("rr%0d_reg", t), 64'(wr_reg), 64'(tbl[t].wreg));
      chk($sformatf("rr%0d_val", t), 64'(wr_val), 64'(tbl[t].wval));
      chk($sformatf("rr%0d_busy", t), 64'(busy), 64'(tbl[t].bsy));
      step;
    end
    req_valid = 0; rsv_valid = 0; rst = 1;
    step;
    rst = 0;
    set_req(1, 7, 32'hFFFF_FFFB); req_valid = 3'b010;
    #1 chk("single_ready", 64'(req_ready), 3'b010);
    step;
    req_valid = 0;
    #1;
    chk("single_setup_sig", 64'(wr_sig), 0);
    chk("single_setup_reg", 64'(wr_reg), 7);
    step;
    chk("single_strobe_sig", 64'(wr_sig), 1);
    step;
    chk("single_after_sig", 64'(wr_sig), 0);
    chk("single_bank7", 64'(bank[7]), 32'hFFFF_FFFB);
    rst = 1;
    step;
    rst = 0;
    set_req(0, 3, 32'h1234_5678); set_req(2, 9, 32'hFFFF_FFFF); req_valid = 3'b101;
    #1 chk("stab_ready", 64'(req_ready), 3'b001);
    step;
    req_valid = 3'b100;
    #1;
    chk("stab_setup_reg", 64'(wr_reg), 3);
    chk("stab_setup_val", 64'(wr_val), 32'h1234_5678);
    chk("stab_setup_ready", 64'(req_ready), 0);
    step;
    chk("stab_strobe_sig", 64'(wr_sig), 1);
    chk("stab_strobe_reg", 64'(wr_reg), 3);
    chk("stab_strobe_val", 64'(wr_val), 32'h1234_5678);
    step;
    chk("stab_idle_ready", 64'(req_ready), 3'b100);
    chk("stab_idle_val", 64'(wr_val), 32'h1234_5678);
    step;
    req_valid = 0;
    #1;
    chk("stab_next_reg", 64'(wr_reg), 9);
    chk("stab_next_val", 64'(wr_val), 32'hFFFF_FFFF);
    step;
    step;
    set_req(1, 8, 32'hA5); req_valid = 3'b010;
    #1 chk("abort_ready", 64'(req_ready), 3'b010);
    step;
    req_valid = 0; rsv_valid = 1; rsv_reg = 5;
    step;
    rsv_valid = 0;
    #1;
    chk("abort_strobe_sig", 64'(wr_sig), 1);
    chk("abort_strobe_busy", 64'(busy), 32'h20);
    rst = 1;
    step;
    req_valid = 3'b111;
    #1;
    chk("abort_sig", 64'(wr_sig), 0);
    chk("abort_busy", 64'(busy), 0);
    chk("abort_ptr_ready", 64'(req_ready), 3'b001);
    rst = 0;
    set_req(0, 2, 32'h77); req_valid = 3'b001;
    step;
    req_valid = 0;
    step;
    chk("post_abort_sig", 64'(wr_sig), 1);
    chk("post_abort_reg", 64'(wr_reg), 2);
    step;
    chk("post_abort_bank2", 64'(bank[2]), 32'h77);
    for (int k = 0; k < 10; k++) begin
      step;
      chk($sformatf("quiet%0d_sig", k), 64'(wr_sig), 0);
      chk($sformatf("quiet%0d_reg", k), 64'(wr_reg), 2);
      chk($sformatf("quiet%0d_val", k), 64'(wr_val), 32'h77);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
